pc_fetch_ctrl: RTL and testbench

Instruction-fetch sequencer that drives the program-counter select mux and the memory address bus for instruction reads. It loads PC from the reset vector, fetches each instruction word plus up to two extension words, presents the complete instruction to execute, then selects the next PC (sequential or branch target). It is the controlling end of the PC mux: it produces the select code, and the PC register outside it consumes the mux output every cycle.

---
 rtl/fetch_pkg.sv | 29 ++
 rtl/pc_fetch_ctrl.sv | 151 +++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer: PC mux select
// codes, the fetch state encoding and the default reset vector address.
package fetch_pkg;

   // Word address the sequencer reads the initial PC from after reset
   localparam logic [15:0] RESET_VEC_DEFAULT = 16'hFFFE;

   // Select codes understood by the PC mux that sits beside this block
   localparam logic [2:0] PC_SEL_NEXT = 3'd0;  // PC + 2
   localparam logic [2:0] PC_SEL_HOLD = 3'd1;  // keep PC
   localparam logic [2:0] PC_SEL_CALC = 3'd2;  // branch target from execute
   localparam logic [2:0] PC_SEL_MDB2 = 3'd3;  // MDB << 1, vectored entry only
   localparam logic [2:0] PC_SEL_MDB  = 3'd4;  // MDB as-is, reset vector load

   // Fetch sequencer states
   typedef enum logic [2:0] {
      ST_VEC    = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXT    = 3'd3,
      ST_ISSUE  = 3'd4
   } fetch_state_e;

   // Instruction reads are always word-aligned, so bit 0 is dropped
   function automatic logic [15:0] wordAlign(input logic [15:0] addr);
      return {addr[15:1], 1'b0};
   endfunction

endpackage

// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch sequencer. Loads the PC from the reset vector, reads an
// instruction word plus up to two extension words, presents the complete
// instruction to execute and then steers the external PC mux to the next
// sequential address or to the branch target.
module pc_fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [15:0] RESET_VEC = RESET_VEC_DEFAULT
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] reg_PC_out,
   input  logic [15:0] MDB,
   input  logic        mem_rdy,
   input  logic [1:0]  ext_words,
   input  logic        exec_done,
   input  logic        branch_taken,
   output logic [2:0]  pc_sel,
   output logic [15:0] MAB,
   output logic        mem_rd,
   output logic [15:0] ir,
   output logic [15:0] ext0,
   output logic [15:0] ext1,
   output logic        instr_valid,
   output logic        illegal
);

   fetch_state_e r_state;
   fetch_state_e w_nextState;
   logic [1:0]   r_extCnt;
   logic         r_extSecond;
   logic [15:0]  r_ir;
   logic [15:0]  r_ext0;
   logic [15:0]  r_ext1;

   // State register; reset always restarts with a reset-vector read
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_VEC;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state decision from the current state and memory/execute handshakes
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_VEC: begin
            if (mem_rdy) w_nextState = ST_FETCH;
         end
         ST_FETCH: begin
            if (mem_rdy) w_nextState = ST_DECODE;
         end
         ST_DECODE: begin
            if ((ext_words == 2'd1) || (ext_words == 2'd2)) begin
               w_nextState = ST_EXT;
            end else begin
               w_nextState = ST_ISSUE;
            end
         end
         ST_EXT: begin
            if ((r_extCnt == 2'd0) || (mem_rdy && (r_extCnt == 2'd1))) begin
               w_nextState = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (exec_done) w_nextState = ST_FETCH;
         end
         default: w_nextState = ST_VEC;
      endcase
   end

   // Instruction/extension registers and the remaining-extension-word counter
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ir        <= 16'h0000;
         r_ext0      <= 16'h0000;
         r_ext1      <= 16'h0000;
         r_extCnt    <= 2'd0;
         r_extSecond <= 1'b0;
      end else begin
         case (r_state)
            ST_FETCH: begin
               if (mem_rdy) begin
                  r_ir   <= MDB;
                  r_ext0 <= 16'h0000;
                  r_ext1 <= 16'h0000;
               end
            end
            ST_DECODE: begin
               r_extCnt    <= (ext_words == 2'd3) ? 2'd0 : ext_words;
               r_extSecond <= 1'b0;
            end
            ST_EXT: begin
               if (mem_rdy && (r_extCnt != 2'd0)) begin
                  if (r_extSecond) begin
                     r_ext1 <= MDB;
                  end else begin
                     r_ext0 <= MDB;
                  end
                  r_extSecond <= 1'b1;
                  r_extCnt    <= r_extCnt - 2'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Mux select, bus request and status outputs; while rst is high they are
   // forced to reset values so a late mem_rdy cannot disturb the PC
   always_comb begin
      pc_sel      = PC_SEL_HOLD;
      MAB         = wordAlign(reg_PC_out);
      mem_rd      = 1'b0;
      instr_valid = 1'b0;
      illegal     = 1'b0;
      if (rst) begin
         MAB    = wordAlign(RESET_VEC);
         mem_rd = 1'b1;
      end else begin
         case (r_state)
            ST_VEC: begin
               MAB    = wordAlign(RESET_VEC);
               mem_rd = 1'b1;
               if (mem_rdy) pc_sel = PC_SEL_MDB;
            end
            ST_FETCH, ST_EXT: begin
               mem_rd = 1'b1;
               if (mem_rdy) pc_sel = PC_SEL_NEXT;
            end
            ST_DECODE: begin
               if (ext_words == 2'd3) illegal = 1'b1;
            end
            ST_ISSUE: begin
               instr_valid = 1'b1;
               if (exec_done && branch_taken) pc_sel = PC_SEL_CALC;
            end
            default: begin
            end
         endcase
      end
   end

   assign ir   = r_ir;
   assign ext0 = r_ext0;
   assign ext1 = r_ext1;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl. The bench owns the PC register, the
// PC mux and a word memory, and runs a table of instruction transactions
// through the fetch sequencer, scoreboarding the presented instruction.
module tb_pc_fetch_ctrl;
   import fetch_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] reg_PC_out;
   logic [15:0] MDB;
   logic        mem_rdy;
   logic [1:0]  ext_words;
   logic        exec_done;
   logic        branch_taken;
   logic [2:0]  pc_sel;
   logic [15:0] MAB;
   logic        mem_rd;
   logic [15:0] ir;
   logic [15:0] ext0;
   logic [15:0] ext1;
   logic        instr_valid;
   logic        illegal;

   logic [15:0] pcReg = 16'h0000;
   logic [15:0] pcMux;
   logic [15:0] calcOut = 16'h0000;
   logic [15:0] memArr [logic [15:0]];

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] pc;
      logic [15:0] w0;
      logic [15:0] w1;
      logic [15:0] w2;
      logic [1:0]  extWords;
      int          waitStates;
      int          execDelay;
      logic        branch;
      logic [15:0] calc;
      logic [15:0] expIr;
      logic [15:0] expExt0;
      logic [15:0] expExt1;
      logic [15:0] expPcIssue;
      logic [15:0] expNextPc;
      int          expCycles;
      logic        expIllegal;
   } vecT;

   vecT vecs [7];
   vecT expQ [$];

   pc_fetch_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .reg_PC_out   (reg_PC_out),
      .MDB          (MDB),
      .mem_rdy      (mem_rdy),
      .ext_words    (ext_words),
      .exec_done    (exec_done),
      .branch_taken (branch_taken),
      .pc_sel       (pc_sel),
      .MAB          (MAB),
      .mem_rd       (mem_rd),
      .ir           (ir),
      .ext0         (ext0),
      .ext1         (ext1),
      .instr_valid  (instr_valid),
      .illegal      (illegal)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // PC mux as it sits outside the sequencer
   always_comb begin
      pcMux = pcReg;
      case (pc_sel)
         3'd0: pcMux = (pcReg + 16'd2) & 16'hFFFE;
         3'd1: pcMux = pcReg;
         3'd2: pcMux = calcOut;
         3'd3: pcMux = {MDB[14:0], 1'b0};
         3'd4: pcMux = MDB;
         default: pcMux = 16'hDEAD;
      endcase
   end

   // PC register consumes the mux output every cycle
   always_ff @(posedge clk) begin
      pcReg <= pcMux;
   end

   assign reg_PC_out = pcReg;

   function automatic logic [15:0] memRead(input logic [15:0] addr);
      if (memArr.exists(addr)) return memArr[addr];
      return 16'h0000;
   endfunction

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Runs one instruction from FETCH through ISSUE/exec_done
   task automatic applyStimulus(input vecT v);
      int          cycles;
      int          issueCnt;
      int          reads;
      int          calcCnt;
      int          illCnt;
      int          nEff;
      int          rdWait;
      bit          done;
      bit          rdBusy;
      logic [15:0] rdAddr;
      logic [15:0] addr;
      nEff = (v.extWords == 2'd3) ? 0 : int'(v.extWords);
      addr = v.pc;
      memArr[addr] = v.w0;
      addr = v.pc + 16'd2;
      if (nEff >= 1) memArr[addr] = v.w1;
      addr = v.pc + 16'd4;
      if (nEff >= 2) memArr[addr] = v.w2;
      expQ.push_back(v);
      ext_words = v.extWords;
      checkOutput("fetchMab", MAB, v.pc);
      checkOutput("fetchRd", {15'b0, mem_rd}, 16'd1);
      cycles = 0; issueCnt = 0; reads = 0; calcCnt = 0; illCnt = 0;
      done = 1'b0; rdBusy = 1'b0; rdWait = 0; rdAddr = 16'h0000;
      while (!done && cycles < 200) begin
         cycles++;
         mem_rdy = 1'b0;
         exec_done = 1'b0;
         branch_taken = 1'b0;
         if (rdBusy) begin
            checkOutput("holdRd", {15'b0, mem_rd}, 16'd1);
            checkOutput("holdMab", MAB, rdAddr);
         end
         if (mem_rd) begin
            if (!rdBusy) begin
               rdBusy = 1'b1;
               rdAddr = MAB;
               rdWait = v.waitStates;
            end
            if (rdWait == 0) begin
               mem_rdy = 1'b1;
               MDB = memRead(rdAddr);
               reads++;
            end else begin
               rdWait--;
            end
         end
         if (instr_valid) begin
            if (issueCnt == 0) begin
               if (expQ.size() == 0) begin
                  checks++; errors++;
                  $display("[TB] FAIL scoreboard: got unexpected issue, expected empty queue");
               end else begin
                  vecT e;
                  e = expQ.pop_front();
                  checkOutput("ir", ir, e.expIr);
                  checkOutput("ext0", ext0, e.expExt0);
                  checkOutput("ext1", ext1, e.expExt1);
                  checkOutput("pcAtIssue", pcReg, e.expPcIssue);
                  checkOutput("issueCycle", 16'(cycles), 16'(e.expCycles));
               end
            end
            if (issueCnt == v.execDelay) begin
               exec_done = 1'b1;
               branch_taken = v.branch;
               calcOut = v.calc;
               done = 1'b1;
            end else begin
               branch_taken = 1'b1;
            end
            issueCnt++;
         end
         #1;
         if (pc_sel == PC_SEL_CALC) calcCnt++;
         if (illegal) illCnt++;
         @(posedge clk);
         if (mem_rdy) rdBusy = 1'b0;
         #1;
      end
      mem_rdy = 1'b0;
      exec_done = 1'b0;
      branch_taken = 1'b0;
      if (!done) begin
         checks++; errors++;
         $display("[TB] FAIL timeout: got no exec_done after %0d cycles, expected issue", cycles);
      end
      checkOutput("reads", 16'(reads), 16'(1 + nEff));
      checkOutput("calcCycles", 16'(calcCnt), v.branch ? 16'd1 : 16'd0);
      checkOutput("illegalPulses", 16'(illCnt), v.expIllegal ? 16'd1 : 16'd0);
      checkOutput("nextPc", pcReg, v.expNextPc);
   endtask

   // Bounds the whole run
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence: reset/vector load, transaction table, mid-EXT reset
   initial begin
      // fields: pc w0 w1 w2 extWords wait execDelay branch calc
      //         expIr expExt0 expExt1 expPcIssue expNextPc expCycles expIllegal
      vecs[0] = '{16'hC000, 16'h4303, 16'h0000, 16'h0000, 2'd0, 0, 0, 1'b0, 16'h0000,
                  16'h4303, 16'h0000, 16'h0000, 16'hC002, 16'hC002, 3, 1'b0};
      vecs[1] = '{16'hC002, 16'h40B2, 16'h1234, 16'h0200, 2'd2, 2, 1, 1'b0, 16'h0000,
                  16'h40B2, 16'h1234, 16'h0200, 16'hC008, 16'hC008, 11, 1'b0};
      vecs[2] = '{16'hC008, 16'h1300, 16'h0000, 16'h0000, 2'd0, 0, 2, 1'b1, 16'hC100,
                  16'h1300, 16'h0000, 16'h0000, 16'hC00A, 16'hC100, 3, 1'b0};
      vecs[3] = '{16'hC100, 16'hABCD, 16'h0000, 16'h0000, 2'd3, 1, 0, 1'b0, 16'h0000,
                  16'hABCD, 16'h0000, 16'h0000, 16'hC102, 16'hC102, 4, 1'b1};
      vecs[4] = '{16'hC102, 16'h5555, 16'h7777, 16'h0000, 2'd1, 0, 0, 1'b1, 16'hFFFC,
                  16'h5555, 16'h7777, 16'h0000, 16'hC106, 16'hFFFC, 4, 1'b0};
      vecs[5] = '{16'hFFFC, 16'h3FFF, 16'hC000, 16'h0000, 2'd1, 0, 0, 1'b0, 16'h0000,
                  16'h3FFF, 16'hC000, 16'h0000, 16'h0000, 16'h0000, 4, 1'b0};
      vecs[6] = '{16'h0000, 16'h1234, 16'h0001, 16'h0002, 2'd2, 0, 3, 1'b0, 16'h0000,
                  16'h1234, 16'h0001, 16'h0002, 16'h0006, 16'h0006, 5, 1'b0};

      memArr[16'hFFFE] = 16'hC000;
      rst = 1'b1; MDB = 16'h0000; mem_rdy = 1'b0; ext_words = 2'd0;
      exec_done = 1'b0; branch_taken = 1'b0;

      // Two reset cycles; the second carries a late mem_rdy that must be ignored
      @(posedge clk); #1;
      checkOutput("rstPcSel", {13'b0, pc_sel}, 16'd1);
      checkOutput("rstMab", MAB, 16'hFFFE);
      checkOutput("rstRd", {15'b0, mem_rd}, 16'd1);
      checkOutput("rstValid", {15'b0, instr_valid}, 16'd0);
      checkOutput("rstIllegal", {15'b0, illegal}, 16'd0);
      checkOutput("rstIr", ir, 16'h0000);
      checkOutput("rstExt0", ext0, 16'h0000);
      checkOutput("rstExt1", ext1, 16'h0000);
      mem_rdy = 1'b1; MDB = 16'h1234; #1;
      checkOutput("rstLateRdyPcSel", {13'b0, pc_sel}, 16'd1);
      @(posedge clk); #1;
      mem_rdy = 1'b0; rst = 1'b0; #1;
      checkOutput("vecMab", MAB, 16'hFFFE);
      checkOutput("vecPcUntouched", pcReg, 16'h0000);

      // Reset-vector load
      mem_rdy = 1'b1; MDB = memRead(16'hFFFE); #1;
      checkOutput("vecPcSel", {13'b0, pc_sel}, 16'd4);
      @(posedge clk); #1;
      mem_rdy = 1'b0;
      checkOutput("vecPc", pcReg, 16'hC000);

      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i]);
      end

      // Mid-EXT reset: fetch a two-extension instruction, stall in EXT, reset
      mem_rdy = 1'b1; MDB = 16'h4BBB; ext_words = 2'd2;
      @(posedge clk); #1;
      mem_rdy = 1'b0;
      @(posedge clk); #1;
      checkOutput("extMab", MAB, 16'h0008);
      checkOutput("extRd", {15'b0, mem_rd}, 16'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      checkOutput("midRstMab", MAB, 16'hFFFE);
      checkOutput("midRstRd", {15'b0, mem_rd}, 16'd1);
      checkOutput("midRstValid", {15'b0, instr_valid}, 16'd0);
      checkOutput("midRstIr", ir, 16'h0000);
      checkOutput("midRstPcSel", {13'b0, pc_sel}, 16'd1);
      mem_rdy = 1'b1; MDB = 16'h5A5A; #1;
      checkOutput("midRstLateRdy", {13'b0, pc_sel}, 16'd1);
      @(posedge clk); #1;
      checkOutput("midRstPcHeld", pcReg, 16'h0008);
      checkOutput("midRstExt0", ext0, 16'h0000);
      mem_rdy = 1'b0; rst = 1'b0; #1;
      checkOutput("revecMab", MAB, 16'hFFFE);
      mem_rdy = 1'b1; MDB = memRead(16'hFFFE); #1;
      checkOutput("revecPcSel", {13'b0, pc_sel}, 16'd4);
      @(posedge clk); #1;
      mem_rdy = 1'b0;
      checkOutput("revecPc", pcReg, 16'hC000);
      checkOutput("revecFetchMab", MAB, 16'hC000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
